// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready
// handshake and shifts it out one bit per clock as a framed serial stream.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last
);

    // Handshake: a word transfers on a rising edge where load_valid and
    // load_ready are both 1; load_ready is combinational, forced low in reset,
    // and the initiator must hold d_in stable until the transfer edge.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_reg_next;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_next;
    logic             xfer;
    logic             ser_out_next;
    logic             ser_valid_next;
    logic             ser_last_next;

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // bit_cnt is 0 in IDLE, so a zero count covers both ready conditions
    // except that the state test keeps the intent explicit.
    always_comb begin
        load_ready = !reset && ((state == IDLE) || (bit_cnt == '0));
        xfer       = load_valid && load_ready;
    end

    always_comb begin
        state_next     = state;
        shift_reg_next = shift_reg;
        bit_cnt_next   = bit_cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    shift_reg_next = d_in;
                    bit_cnt_next   = CNT_LOAD;
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
                    shift_reg_next = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
                    bit_cnt_next   = bit_cnt - CW'(1);
                end else if (xfer) begin
                    shift_reg_next = d_in;
                    bit_cnt_next   = CNT_LOAD;
                end else begin
                    shift_reg_next = '0;
                    state_next     = IDLE;
                end
            end
            default: begin
                shift_reg_next = '0;
                bit_cnt_next   = '0;
                state_next     = IDLE;
            end
        endcase
    end

    // Serial outputs are precomputed from the next state so they come straight
    // from flops and line up with the bit currently at the head.
    always_comb begin
        ser_valid_next = (state_next == SHIFT);
        ser_out_next   = ser_valid_next && head_bit(shift_reg_next);
        ser_last_next  = ser_valid_next && (bit_cnt_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_reg_next;
            bit_cnt   <= bit_cnt_next;
            ser_out   <= ser_out_next;
            ser_valid <= ser_valid_next;
            ser_last  <= ser_last_next;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer: MSB-first WIDTH=4, LSB-first
// WIDTH=4 and WIDTH=1 instances share one clock and reset.
module tb_piso_serializer;

    logic clk;
    logic reset;

    logic [3:0] d_in;
    logic       load_valid;
    logic       load_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;

    logic [3:0] d_in_l;
    logic       load_valid_l;
    logic       load_ready_l;
    logic       ser_out_l;
    logic       ser_valid_l;
    logic       ser_last_l;

    logic [0:0] d_in_w;
    logic       load_valid_w;
    logic       load_ready_w;
    logic       ser_out_w;
    logic       ser_valid_w;
    logic       ser_last_w;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .load_valid(load_valid),
        .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_last(ser_last)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .d_in(d_in_l), .load_valid(load_valid_l),
        .load_ready(load_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .ser_last(ser_last_l)
    );

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_w (
        .clk(clk), .reset(reset), .d_in(d_in_w), .load_valid(load_valid_w),
        .load_ready(load_ready_w), .ser_out(ser_out_w), .ser_valid(ser_valid_w),
        .ser_last(ser_last_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({ser_out, ser_valid, ser_last} !== 3'b000) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d got=%b want=000", c, {ser_out, ser_valid, ser_last});
            end
            total++;
            if (load_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready cycle=%0d got=%b want=0", c, load_ready);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (load_ready !== 1'b1 || load_ready_w !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b%b want=11", load_ready, load_ready_w);
        end
    endtask

    task automatic test_single;
        logic [3:0] w;
        w = 4'b1011;
        d_in = w;
        load_valid = 1'b1;
        #1;
        total++;
        if (load_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_ready_edge0 got=%b want=1", load_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            d_in = 4'b0000;
            #1;
            total++;
            if ({ser_out, ser_valid, ser_last, load_ready} !== {w[3-k], 1'b1, (k == 3), (k == 3)}) begin
                bad++;
                $display("FAIL single_bit k=%0d got(out,valid,last,ready)=%b want=%b", k,
                         {ser_out, ser_valid, ser_last, load_ready}, {w[3-k], 1'b1, (k == 3), (k == 3)});
            end
        end
        @(negedge clk);
        total++;
        if ({ser_valid, ser_last, ser_out} !== 3'b000) begin
            bad++;
            $display("FAIL single_end got=%b want=000", {ser_valid, ser_last, ser_out});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bits;
        int xfer_edges[$];
        bits = 8'b1100_0011;
        d_in = 4'b1100;
        load_valid = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c == 1) d_in = 4'b0011;
                if (c == 5) load_valid = 1'b0;
                #1;
                total++;
                if (c <= 8) begin
                    if ({ser_out, ser_valid, ser_last} !== {bits[8-c], 1'b1, (c == 4 || c == 8)}) begin
                        bad++;
                        $display("FAIL b2b_bit cycle=%0d got=%b want=%b", c,
                                 {ser_out, ser_valid, ser_last}, {bits[8-c], 1'b1, (c == 4 || c == 8)});
                    end
                end else if (ser_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle cycle=%0d got=%b want=0", c, ser_valid);
                end
            end
            if (load_valid && load_ready) xfer_edges.push_back(c);
        end
        total++;
        if (xfer_edges.size() != 2 || xfer_edges[0] != 0 || xfer_edges[1] != 4) begin
            bad++;
            $display("FAIL b2b_transfers got_count=%0d want=2 at edges 0,4", xfer_edges.size());
        end
    endtask

    task automatic test_load_while_busy;
        logic [3:0] w;
        w = 4'b0001;
        d_in = w;
        load_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            load_valid = (c == 2 || c == 3);
            d_in = (c == 2 || c == 3) ? 4'b1111 : 4'b0000;
            #1;
            total++;
            if (c <= 4) begin
                if ({ser_out, ser_valid, ser_last} !== {w[4-c], 1'b1, (c == 4)}) begin
                    bad++;
                    $display("FAIL busy_bit cycle=%0d got=%b want=%b", c,
                             {ser_out, ser_valid, ser_last}, {w[4-c], 1'b1, (c == 4)});
                end
            end else if ({ser_out, ser_valid, ser_last} !== 3'b000) begin
                bad++;
                $display("FAIL busy_idle cycle=%0d got=%b want=000", c, {ser_out, ser_valid, ser_last});
            end
            if (c == 2 || c == 3) begin
                total++;
                if (load_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_ready cycle=%0d got=%b want=0", c, load_ready);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [3:0] w;
        w = 4'b1010;
        d_in = w;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({ser_out, ser_valid} !== {w[2], 1'b1}) begin
            bad++;
            $display("FAIL mid_bit1 got=%b want=%b", {ser_out, ser_valid}, {w[2], 1'b1});
        end
        reset = 1'b1;
        load_valid = 1'b1;
        d_in = 4'b1111;
        #1;
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_ready_in_reset got=%b want=0", load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        load_valid = 1'b0;
        #1;
        total++;
        if ({ser_out, ser_valid, ser_last, load_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL mid_abort got(out,valid,last,ready)=%b want=0001", {ser_out, ser_valid, ser_last, load_ready});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (ser_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_no_bits cycle=%0d got=%b want=0", c, ser_valid);
            end
        end
        w = 4'b0110;
        d_in = w;
        load_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            total++;
            if ({ser_out, ser_valid, ser_last} !== {w[3-k], 1'b1, (k == 3)}) begin
                bad++;
                $display("FAIL mid_new_frame k=%0d got=%b want=%b", k,
                         {ser_out, ser_valid, ser_last}, {w[3-k], 1'b1, (k == 3)});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lsb_first;
        logic [3:0] w;
        w = 4'b0001;
        d_in_l = w;
        load_valid_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            load_valid_l = 1'b0;
            #1;
            total++;
            if ({ser_out_l, ser_valid_l, ser_last_l} !== {w[k], 1'b1, (k == 3)}) begin
                bad++;
                $display("FAIL lsb_bit k=%0d got=%b want=%b", k,
                         {ser_out_l, ser_valid_l, ser_last_l}, {w[k], 1'b1, (k == 3)});
            end
        end
        @(negedge clk);
        total++;
        if (ser_valid_l !== 1'b0) begin
            bad++;
            $display("FAIL lsb_end got=%b want=0", ser_valid_l);
        end
    endtask

    task automatic test_sweep;
        int idx = 0;
        int got_words = 0;
        int valid_cycles = 0;
        logic [3:0] acc = 4'b0000;
        logic [3:0] exp;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ser_valid === 1'b1) begin
                valid_cycles++;
                acc = {acc[2:0], ser_out};
                if (ser_last === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sweep_unexpected got=%b want=none", acc);
                    end else begin
                        exp = exp_q.pop_front();
                        if (acc !== exp) begin
                            bad++;
                            $display("FAIL sweep_word n=%0d got=%b want=%b", got_words, acc, exp);
                        end
                    end
                    got_words++;
                end
            end
            load_valid = (idx < 16);
            d_in = 4'(idx);
            #1;
            if (load_valid && load_ready) begin
                exp_q.push_back(d_in);
                idx++;
            end
        end
        load_valid = 1'b0;
        total++;
        if (got_words != 16 || exp_q.size() != 0 || valid_cycles != 64) begin
            bad++;
            $display("FAIL sweep_totals got words=%0d pending=%0d valid=%0d want 16/0/64",
                     got_words, exp_q.size(), valid_cycles);
        end
    endtask

    task automatic test_width1;
        logic prev;
        prev = 1'b0;
        load_valid_w = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
                total++;
                if ({ser_out_w, ser_valid_w, ser_last_w} !== {prev, 2'b11}) begin
                    bad++;
                    $display("FAIL w1_bit cycle=%0d got=%b want=%b", c,
                             {ser_out_w, ser_valid_w, ser_last_w}, {prev, 2'b11});
                end
            end
            d_in_w = (c % 2 == 0) ? 1'b1 : 1'b0;
            prev = d_in_w[0];
            if (c == 6) load_valid_w = 1'b0;
            #1;
            total++;
            if (load_ready_w !== 1'b1) begin
                bad++;
                $display("FAIL w1_ready cycle=%0d got=%b want=1", c, load_ready_w);
            end
        end
        @(negedge clk);
        total++;
        if (ser_valid_w !== 1'b0) begin
            bad++;
            $display("FAIL w1_end got=%b want=0", ser_valid_w);
        end
    endtask

    initial begin
        reset = 1'b1;
        d_in = '0;
        load_valid = 1'b0;
        d_in_l = '0;
        load_valid_l = 1'b0;
        d_in_w = '0;
        load_valid_w = 1'b0;
        @(negedge clk);
        test_reset;
        test_single;
        @(negedge clk);
        test_back_to_back;
        @(negedge clk);
        test_load_while_busy;
        @(negedge clk);
        test_reset_mid_frame;
        test_lsb_first;
        test_sweep;
        @(negedge clk);
        test_width1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
